decsym_ftab_arbiter: RTL and testbench
======================================

Name: decsym_ftab_arbiter

Overview:
- Shares one Huffman lookup-table port (index stream out, value stream back) between two DecSym symbol-decoder pages.
- Round-robin arbitration of index requests; in-order routing of table values back to the issuing page via a tag FIFO.
- Per-page end-of-stream sequencing: each page's EOS is delivered in order, then a single EOS is sent to and collected from the table.
- Sits between two DecSym pages (their ftabind/ftabval streams) and the shared table page.

Parameters:
AW, 8, index width
DW, 8, table value width
DEPTH, 4, max tag-FIFO entries (outstanding lookups plus EOS markers); power of 2, at least 2

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
r0_ind_d  in  AW  page 0 lookup index
r0_ind_e  in  1  page 0 index-stream EOS flag
r0_ind_v  in  1  page 0 index valid
r0_ind_b  out  1  back-pressure to page 0
r0_val_d  out  DW  value returned to page 0
r0_val_e  out  1  page 0 value-stream EOS flag
r0_val_v  out  1  value valid to page 0
r0_val_b  in  1  page 0 back-pressure
r1_ind_d, r1_ind_e, r1_ind_v, r1_ind_b, r1_val_d, r1_val_e, r1_val_v, r1_val_b  same as r0_*, for page 1
t_ind_d  out  AW  index to table
t_ind_e  out  1  table index EOS
t_ind_v  out  1  table index valid
t_ind_b  in  1  table back-pressure
t_val_d  in  DW  table value
t_val_e  in  1  table value EOS
t_val_v  in  1  table value valid
t_val_b  out  1  back-pressure to table

Behaviour:
- Handshake:
  - A token transfers on a cycle when its _v=1 and the receiving side's _b=0.
  - _e=1 marks an EOS token; its _d is don't-care.
- Reset (synchronous):
  - Outputs: all _v=0, _e=0, _d=0; r0_ind_b=r1_ind_b=t_val_b=1 during reset.
  - State: FIFO empty, closed0=closed1=0, round-robin pointer=0, state RUN.
- Output register:
  - t_ind_* comes from a one-entry register.
  - The register may load when it is empty or draining that same cycle.
- Request acceptance (state RUN):
  - Eligible requester i: r{i}_ind_v=1, closed{i}=0, and FIFO count<DEPTH at cycle start. There is no same-cycle pop bypass.
  - Non-EOS token additionally requires the output register loadable. EOS tokens need only a FIFO slot.
  - If both are eligible, grant the pointer side. After any grant, the pointer moves to the other side.
  - r{i}_ind_b=0 only for the granted side.
- Grant effects:
  - Non-EOS grant: push tag {eos=0,id=i}; load the output register with r{i}_ind_d. t_ind_v=1 appears on the next cycle (latency 1).
  - EOS grant: push {eos=1,id=i}; set closed{i}. Nothing is sent to the table.
- Response routing (combinational from the FIFO head):
  - Head {0,i}: r{i}_val_d=t_val_d, r{i}_val_v=t_val_v, t_val_b=r{i}_val_b. Pop on transfer. The other side's _v=0.
  - Head {1,i}: r{i}_val_v=1, r{i}_val_e=1, t_val_b=1. Pop when r{i}_val_b=0.
  - FIFO empty: t_val_b=1, both r_val_v=0.
  - In RUN, a t_val token with e=1 is never accepted (t_val_b=1 whenever the head is not a data tag).
- Simultaneous push and pop: allowed; count unchanged.
- State machine:
  - RUN: when closed0&closed1, go to FLUSH.
  - FLUSH: no grants; both r_ind_b=1. When FIFO empty and output register empty, go to EOS_OUT.
  - EOS_OUT: t_ind_v=1, t_ind_e=1. On transfer, go to WAIT_EOS.
  - WAIT_EOS: t_val_b=0 only for e=1 tokens; t_val tokens with e=0 are held (t_val_b=1). On an EOS transfer: clear closed0/1, pointer=0, go to RUN.
- Reset mid-operation: in-flight tags, the output register and closed flags are discarded with no EOS generated.

Test Plan:
- Single requester: r0 sends indices 0x10,0x11,0x12; table returns 0xA0,0xA1,0xA2 with 0-cycle lag -> t_ind shows each index 1 cycle after acceptance; r0_val gets A0,A1,A2 in order; r1_val_v stays 0.
- Contention: both valid continuously (r0: 0x01,0x02; r1: 0x81,0x82) -> issue order 0x01,0x81,0x02,0x82; values return in that order to r0,r1,r0,r1.
- FIFO full, DEPTH=4: t_val_v held 0 while both pages push -> exactly 4 grants, then r0_ind_b=r1_ind_b=1; one value returned -> exactly one new grant the cycle after the pop.
- EOS ordering: r0 sends 0x05 then EOS; r1 sends 0x06 then EOS -> r0_val gets value then e=1 token; r1 likewise; one t_ind EOS only after the FIFO drains; table EOS returns and state is RUN with both pages accepted again.
- Back-pressure: r1_val_b=1 with a r1 data tag at the head -> t_val_b=1, nothing popped; deassert -> value delivered and popped that cycle.
- Reset asserted with 3 lookups outstanding -> next cycle all _v=0, FIFO empty; a new r0 request completes normally after reset releases.

Source files
------------

// File: rtl/decsym_ftab_arbiter.sv
// Shares one Huffman table port between two DecSym pages: round-robin index arbitration,
// in-order value routing through a tag FIFO, and EOS sequencing across both pages.
module decsym_ftab_arbiter #(
   parameter int unsigned AW    = 8,
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic [AW-1:0] r0_ind_d,
   input  logic          r0_ind_e,
   input  logic          r0_ind_v,
   output logic          r0_ind_b,
   output logic [DW-1:0] r0_val_d,
   output logic          r0_val_e,
   output logic          r0_val_v,
   input  logic          r0_val_b,
   input  logic [AW-1:0] r1_ind_d,
   input  logic          r1_ind_e,
   input  logic          r1_ind_v,
   output logic          r1_ind_b,
   output logic [DW-1:0] r1_val_d,
   output logic          r1_val_e,
   output logic          r1_val_v,
   input  logic          r1_val_b,
   output logic [AW-1:0] t_ind_d,
   output logic          t_ind_e,
   output logic          t_ind_v,
   input  logic          t_ind_b,
   input  logic [DW-1:0] t_val_d,
   input  logic          t_val_e,
   input  logic          t_val_v,
   output logic          t_val_b
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {StRun, StFlush, StEosOut, StWaitEos} stateT;

   stateT stateQ, stateD;
   logic [1:0] closedQ, closedD;
   logic ptrQ, ptrD;
   logic outValidQ, outValidD;
   logic [AW-1:0] outDataQ, outDataD;

   // Tag = {eos, id}
   logic [1:0] tagMem [DEPTH];
   logic [PW-1:0] rdPtrQ, wrPtrQ;
   logic [CW-1:0] countQ, countD;

   logic fifoEmpty, fifoFull, headEos, headId;
   logic loadable, runActive;
   logic elig0, elig1, grantAny, grantId, grantEos;
   logic [AW-1:0] grantData;
   logic pop, push;
   logic eosBack;

   assign fifoEmpty = (countQ == '0);
   assign fifoFull  = (countQ == CW'(DEPTH));
   assign headEos   = tagMem[rdPtrQ][1];
   assign headId    = tagMem[rdPtrQ][0];

   // The output register can take a new index when empty or being drained this cycle.
   assign loadable  = !outValidQ || !t_ind_b;
   assign runActive = (stateQ == StRun) && !reset;

   assign elig0 = runActive && r0_ind_v && !closedQ[0] && !fifoFull && (r0_ind_e || loadable);
   assign elig1 = runActive && r1_ind_v && !closedQ[1] && !fifoFull && (r1_ind_e || loadable);

   assign grantAny  = elig0 || elig1;
   assign grantId   = (elig0 && elig1) ? ptrQ : elig1;
   assign grantEos  = grantId ? r1_ind_e : r0_ind_e;
   assign grantData = grantId ? r1_ind_d : r0_ind_d;
   assign push      = grantAny;

   assign r0_ind_b = !(grantAny && !grantId);
   assign r1_ind_b = !(grantAny && grantId);

   assign t_ind_v = !reset && ((stateQ == StEosOut) || outValidQ);
   assign t_ind_e = !reset && (stateQ == StEosOut);
   assign t_ind_d = reset ? '0 : outDataQ;

   assign eosBack = (stateQ == StWaitEos) && t_val_v && t_val_e;

   // Response routing from the FIFO head
   always_comb begin
      r0_val_d = '0;
      r0_val_e = 1'b0;
      r0_val_v = 1'b0;
      r1_val_d = '0;
      r1_val_e = 1'b0;
      r1_val_v = 1'b0;
      t_val_b  = 1'b1;
      pop      = 1'b0;
      if (reset) begin
         t_val_b = 1'b1;
      end else if (stateQ == StWaitEos) begin
         t_val_b = !t_val_e;
      end else if (!fifoEmpty) begin
         if (!headEos) begin
            if (headId) begin
               r1_val_d = t_val_d;
               r1_val_v = t_val_v;
               t_val_b  = r1_val_b;
               pop      = t_val_v && !r1_val_b;
            end else begin
               r0_val_d = t_val_d;
               r0_val_v = t_val_v;
               t_val_b  = r0_val_b;
               pop      = t_val_v && !r0_val_b;
            end
         end else begin
            if (headId) begin
               r1_val_v = 1'b1;
               r1_val_e = 1'b1;
               pop      = !r1_val_b;
            end else begin
               r0_val_v = 1'b1;
               r0_val_e = 1'b1;
               pop      = !r0_val_b;
            end
         end
      end
   end

   always_comb begin
      stateD    = stateQ;
      closedD   = closedQ;
      ptrD      = ptrQ;
      outValidD = outValidQ;
      outDataD  = outDataQ;
      countD    = countQ + CW'(push) - CW'(pop);

      if (outValidQ && !t_ind_b) begin
         outValidD = 1'b0;
      end
      if (grantAny) begin
         ptrD = !grantId;
         if (grantEos) begin
            closedD[grantId] = 1'b1;
         end else begin
            outValidD = 1'b1;
            outDataD  = grantData;
         end
      end

      unique case (stateQ)
         StRun: begin
            if (closedQ[0] && closedQ[1]) begin
               stateD = StFlush;
            end
         end
         StFlush: begin
            if (fifoEmpty && !outValidQ) begin
               stateD = StEosOut;
            end
         end
         StEosOut: begin
            if (!t_ind_b) begin
               stateD = StWaitEos;
            end
         end
         StWaitEos: begin
            if (eosBack) begin
               closedD = 2'b00;
               ptrD    = 1'b0;
               stateD  = StRun;
            end
         end
         default: stateD = StRun;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stateQ    <= StRun;
         closedQ   <= 2'b00;
         ptrQ      <= 1'b0;
         outValidQ <= 1'b0;
         outDataQ  <= '0;
         rdPtrQ    <= '0;
         wrPtrQ    <= '0;
         countQ    <= '0;
      end else begin
         stateQ    <= stateD;
         closedQ   <= closedD;
         ptrQ      <= ptrD;
         outValidQ <= outValidD;
         outDataQ  <= outDataD;
         countQ    <= countD;
         if (push) begin
            wrPtrQ <= wrPtrQ + 1'b1;
         end
         if (pop) begin
            rdPtrQ <= rdPtrQ + 1'b1;
         end
      end
   end

   // Tag storage needs no reset; occupancy is tracked by countQ.
   always_ff @(posedge clock) begin
      if (push) begin
         tagMem[wrPtrQ] <= {grantEos, grantId};
      end
   end

endmodule

// File: tb/tb_decsym_ftab_arbiter.sv
// Directed self-checking bench for decsym_ftab_arbiter with hand-computed expectations.
module tb_decsym_ftab_arbiter;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] r0_ind_d, r1_ind_d, r0_val_d, r1_val_d, t_ind_d, t_val_d;
   logic       r0_ind_e, r0_ind_v, r0_ind_b, r0_val_e, r0_val_v, r0_val_b;
   logic       r1_ind_e, r1_ind_v, r1_ind_b, r1_val_e, r1_val_v, r1_val_b;
   logic       t_ind_e, t_ind_v, t_ind_b, t_val_e, t_val_v, t_val_b;

   int nChecks = 0;
   int nPass   = 0;

   decsym_ftab_arbiter #(.AW(8), .DW(8), .DEPTH(4)) dut (
      .clock(clock), .reset(reset),
      .r0_ind_d(r0_ind_d), .r0_ind_e(r0_ind_e), .r0_ind_v(r0_ind_v), .r0_ind_b(r0_ind_b),
      .r0_val_d(r0_val_d), .r0_val_e(r0_val_e), .r0_val_v(r0_val_v), .r0_val_b(r0_val_b),
      .r1_ind_d(r1_ind_d), .r1_ind_e(r1_ind_e), .r1_ind_v(r1_ind_v), .r1_ind_b(r1_ind_b),
      .r1_val_d(r1_val_d), .r1_val_e(r1_val_e), .r1_val_v(r1_val_v), .r1_val_b(r1_val_b),
      .t_ind_d(t_ind_d), .t_ind_e(t_ind_e), .t_ind_v(t_ind_v), .t_ind_b(t_ind_b),
      .t_val_d(t_val_d), .t_val_e(t_val_e), .t_val_v(t_val_v), .t_val_b(t_val_b)
   );

   always #5 clock = ~clock;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got === exp) nPass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      r0_ind_d = '0; r0_ind_e = 0; r0_ind_v = 0; r0_val_b = 0;
      r1_ind_d = '0; r1_ind_e = 0; r1_ind_v = 0; r1_val_b = 0;
      t_ind_b  = 0;  t_val_d  = '0; t_val_e = 0; t_val_v = 0;
   endtask

   task automatic doReset();
      idle();
      reset = 1;
      tick();
      tick();
      reset = 0;
   endtask

   // One data-only cycle: drive, settle, compare, advance.
   task automatic row(input string tag,
                      input logic r0v, input logic [7:0] r0d, input logic r1v, input logic [7:0] r1d,
                      input logic tvv, input logic [7:0] tvd,
                      input logic eb0, input logic eb1, input logic eTv, input logic [7:0] eTd,
                      input logic ev0, input logic ev1);
      r0_ind_v = r0v; r0_ind_d = r0d; r1_ind_v = r1v; r1_ind_d = r1d;
      t_val_v  = tvv; t_val_d  = tvd;
      #1;
      checkEq({tag, " r0_ind_b"}, r0_ind_b, eb0);
      checkEq({tag, " r1_ind_b"}, r1_ind_b, eb1);
      checkEq({tag, " t_ind_v"}, t_ind_v, eTv);
      if (eTv) checkEq({tag, " t_ind_d"}, t_ind_d, eTd);
      checkEq({tag, " r0_val_v"}, r0_val_v, ev0);
      checkEq({tag, " r1_val_v"}, r1_val_v, ev1);
      if (ev0) checkEq({tag, " r0_val_d"}, r0_val_d, tvd);
      if (ev1) checkEq({tag, " r1_val_d"}, r1_val_d, tvd);
      tick();
   endtask

   int grants;

   initial begin
      idle();
      reset = 1;
      #2;
      r0_ind_v = 1;
      #1;
      checkEq("rst r0_ind_b", r0_ind_b, 1);
      checkEq("rst r1_ind_b", r1_ind_b, 1);
      checkEq("rst t_val_b", t_val_b, 1);
      checkEq("rst t_ind_v", t_ind_v, 0);
      checkEq("rst r0_val_v", r0_val_v, 0);
      doReset();

      // Single requester
      row("single1", 1, 8'h10, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
      row("single2", 1, 8'h11, 0, 0, 1, 8'hA0, 0, 1, 1, 8'h10, 1, 0);
      row("single3", 1, 8'h12, 0, 0, 1, 8'hA1, 0, 1, 1, 8'h11, 1, 0);
      row("single4", 0, 8'h00, 0, 0, 1, 8'hA2, 1, 1, 1, 8'h12, 1, 0);
      row("single5", 0, 8'h00, 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0, 0);

      // Contention
      doReset();
      row("cont1", 1, 8'h01, 1, 8'h81, 0, 8'h00, 0, 1, 0, 8'h00, 0, 0);
      row("cont2", 1, 8'h02, 1, 8'h81, 1, 8'hC1, 1, 0, 1, 8'h01, 1, 0);
      row("cont3", 1, 8'h02, 1, 8'h82, 1, 8'hC2, 0, 1, 1, 8'h81, 0, 1);
      row("cont4", 0, 8'h00, 1, 8'h82, 1, 8'hC3, 1, 0, 1, 8'h02, 1, 0);
      row("cont5", 0, 8'h00, 0, 8'h00, 1, 8'hC4, 1, 1, 1, 8'h82, 0, 1);

      // FIFO full
      doReset();
      grants = 0;
      r0_ind_v = 1; r0_ind_d = 8'h40; r1_ind_v = 1; r1_ind_d = 8'hC0;
      for (int i = 0; i < 6; i++) begin
         #1;
         if (!r0_ind_b || !r1_ind_b) grants++;
         tick();
      end
      checkEq("full grants", grants, 4);
      t_val_v = 1; t_val_d = 8'h55;
      #1;
      checkEq("full pop r0_ind_b", r0_ind_b, 1);
      checkEq("full pop r1_ind_b", r1_ind_b, 1);
      checkEq("full pop r0_val_v", r0_val_v, 1);
      checkEq("full pop t_val_b", t_val_b, 0);
      tick();
      t_val_v = 0;
      #1;
      checkEq("full regrant r0_ind_b", r0_ind_b, 0);
      checkEq("full regrant r1_ind_b", r1_ind_b, 1);
      tick();
      #1;
      checkEq("full again r0_ind_b", r0_ind_b, 1);
      checkEq("full again r1_ind_b", r1_ind_b, 1);
      tick();

      // EOS ordering
      doReset();
      r0_ind_v = 1; r0_ind_d = 8'h05; r1_ind_v = 1; r1_ind_d = 8'h06;
      #1; checkEq("eos c1 r0_ind_b", r0_ind_b, 0); tick();
      r0_ind_e = 1;
      #1; checkEq("eos c2 r1_ind_b", r1_ind_b, 0); checkEq("eos c2 r0_ind_b", r0_ind_b, 1); tick();
      r1_ind_e = 1;
      #1; checkEq("eos c3 r0_ind_b", r0_ind_b, 0); checkEq("eos c3 t_ind_d", t_ind_d, 8'h06); tick();
      #1; checkEq("eos c4 r1_ind_b", r1_ind_b, 0); checkEq("eos c4 closed r0_ind_b", r0_ind_b, 1);
      checkEq("eos c4 t_ind_v", t_ind_v, 0); tick();
      r1_ind_v = 0; t_val_v = 1; t_val_d = 8'hB5;
      #1; checkEq("eos c5 r0_val_v", r0_val_v, 1); checkEq("eos c5 r0_val_d", r0_val_d, 8'hB5);
      checkEq("eos c5 r0_val_e", r0_val_e, 0); checkEq("eos c5 r0_ind_b", r0_ind_b, 1); tick();
      t_val_d = 8'hB6;
      #1; checkEq("eos c6 r1_val_v", r1_val_v, 1); checkEq("eos c6 r1_val_d", r1_val_d, 8'hB6);
      checkEq("eos c6 r0_val_v", r0_val_v, 0); checkEq("eos c6 t_ind_v", t_ind_v, 0); tick();
      t_val_v = 0;
      #1; checkEq("eos c7 r0_val_v", r0_val_v, 1); checkEq("eos c7 r0_val_e", r0_val_e, 1);
      checkEq("eos c7 t_val_b", t_val_b, 1); tick();
      #1; checkEq("eos c8 r1_val_v", r1_val_v, 1); checkEq("eos c8 r1_val_e", r1_val_e, 1);
      checkEq("eos c8 r0_val_v", r0_val_v, 0); tick();
      #1; checkEq("eos c9 t_ind_v", t_ind_v, 0); tick();
      #1; checkEq("eos c10 t_ind_v", t_ind_v, 1); checkEq("eos c10 t_ind_e", t_ind_e, 1);
      checkEq("eos c10 r0_ind_b", r0_ind_b, 1); tick();
      t_val_v = 1; t_val_e = 0;
      #1; checkEq("eos c11 hold t_val_b", t_val_b, 1); checkEq("eos c11 t_ind_v", t_ind_v, 0); tick();
      t_val_e = 1;
      #1; checkEq("eos c12 accept t_val_b", t_val_b, 0); tick();
      t_val_v = 0; t_val_e = 0;
      r0_ind_e = 0; r0_ind_d = 8'h07; r1_ind_v = 1; r1_ind_e = 0; r1_ind_d = 8'h08;
      #1; checkEq("eos c13 r0_ind_b", r0_ind_b, 0); tick();
      r0_ind_v = 0;
      #1; checkEq("eos c14 r1_ind_b", r1_ind_b, 0); tick();
      idle();

      // Back-pressure on page 1
      doReset();
      r1_ind_v = 1; r1_ind_d = 8'h33;
      #1; checkEq("bp grant r1_ind_b", r1_ind_b, 0); tick();
      r1_ind_v = 0; r1_val_b = 1; t_val_v = 1; t_val_d = 8'h77;
      #1; checkEq("bp hold t_val_b", t_val_b, 1); checkEq("bp hold r1_val_v", r1_val_v, 1); tick();
      #1; checkEq("bp hold2 t_val_b", t_val_b, 1); tick();
      r1_val_b = 0;
      #1; checkEq("bp go t_val_b", t_val_b, 0); checkEq("bp go r1_val_d", r1_val_d, 8'h77); tick();
      t_val_v = 0;
      #1; checkEq("bp after r1_val_v", r1_val_v, 0); checkEq("bp after t_val_b", t_val_b, 1); tick();

      // Reset with lookups outstanding
      doReset();
      for (int i = 0; i < 3; i++) begin
         r0_ind_v = 1; r0_ind_d = 8'h20 + 8'(i);
         #1; checkEq("mid grant r0_ind_b", r0_ind_b, 0); tick();
      end
      reset = 1;
      #1; checkEq("mid rst t_ind_v", t_ind_v, 0); checkEq("mid rst r0_ind_b", r0_ind_b, 1);
      checkEq("mid rst r0_val_v", r0_val_v, 0); checkEq("mid rst t_val_b", t_val_b, 1); tick();
      reset = 0; r0_ind_v = 0; t_val_v = 1; t_val_d = 8'h99;
      #1; checkEq("post rst r0_val_v", r0_val_v, 0); checkEq("post rst t_val_b", t_val_b, 1);
      checkEq("post rst t_ind_v", t_ind_v, 0); tick();
      t_val_v = 0; r0_ind_v = 1; r0_ind_d = 8'h2A;
      #1; checkEq("post req r0_ind_b", r0_ind_b, 0); tick();
      r0_ind_v = 0; t_val_v = 1; t_val_d = 8'hAA;
      #1; checkEq("post t_ind_d", t_ind_d, 8'h2A); checkEq("post t_ind_v", t_ind_v, 1);
      checkEq("post r0_val_v", r0_val_v, 1); checkEq("post r0_val_d", r0_val_d, 8'hAA); tick();
      t_val_v = 0;
      #1; checkEq("post done r0_val_v", r0_val_v, 0); checkEq("post done t_ind_v", t_ind_v, 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
